// File: rtl/seq_scheduler.sv
// seq_scheduler: per-frame run controller for the DSP sequencer (release, wait for done, record status).
// Define SEQ_SCHED_WATCHDOG_EN to enable the RUN-state TIMEOUT watchdog; otherwise RUN waits for seq_done forever.
module seq_scheduler #(
  parameter int FRAME_W = 4,
  parameter int CYC_W   = 10,
  parameter int TIMEOUT = 1000,
  parameter int SETTLE  = 2
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               enable,
  input  logic               frame_strobe,
  input  logic               clear,
  input  logic               seq_done,
  input  logic               seq_error,
  output logic               seq_run,
  output logic [FRAME_W-1:0] frame,
  output logic               busy,
  output logic               frame_done,
  output logic [CYC_W-1:0]   cycles_last,
  output logic [7:0]         overrun_cnt,
  output logic               error_flag,
  output logic               timeout_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int               SET_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE - 1);
  localparam logic [CYC_W-1:0] RUN_LIMIT   = CYC_W'(TIMEOUT - 1);
`ifdef SEQ_SCHED_WATCHDOG_EN
  localparam bit               WD_ON       = 1'b1;
`else
  localparam bit               WD_ON       = 1'b0;
`endif

  function automatic logic [CYC_W-1:0] sat_inc_cyc(input logic [CYC_W-1:0] v);
    return (v == {CYC_W{1'b1}}) ? v : v + CYC_W'(1);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [CYC_W-1:0]   run_cnt;
  logic [CYC_W-1:0]   run_next;
  logic               in_run;
  logic               wd_hit;
  logic               run_stop;
  logic               accept;
  logic               dropped;

  // run_next is the number of RUN cycles including the current one
  assign in_run   = (state == RUN);
  assign run_next = sat_inc_cyc(run_cnt);
  assign wd_hit   = WD_ON && (run_cnt == RUN_LIMIT);
  assign run_stop = in_run && (seq_done || wd_hit);
  assign accept   = (state == IDLE) && frame_strobe && enable;
  assign dropped  = (state != IDLE) && frame_strobe;

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      run_cnt     <= '0;
      seq_run     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame       <= '0;
      cycles_last <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            frame      <= frame + FRAME_W'(1);
            settle_cnt <= '0;
            seq_run    <= 1'b1;
            busy       <= 1'b1;
            state      <= START;
          end
        end
        START: begin
          // seq_done is ignored here while the sequencer's done pipeline flushes
          if (settle_cnt == SETTLE_LAST) begin
            run_cnt <= '0;
            state   <= RUN;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        RUN: begin
          if (run_stop) begin
            cycles_last <= run_next;
            seq_run     <= 1'b0;
            frame_done  <= 1'b1;
            state       <= FINISH;
          end else begin
            run_cnt <= run_next;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          seq_run <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Sticky status; clear takes priority over any same-cycle set or increment
  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      overrun_cnt  <= '0;
      error_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else if (clear) begin
      overrun_cnt  <= '0;
      error_flag   <= 1'b0;
      timeout_flag <= 1'b0;
    end else begin
      if (dropped) begin
        overrun_cnt <= sat_inc8(overrun_cnt);
      end
      if (in_run && seq_error) begin
        error_flag <= 1'b1;
      end
      if (run_stop && !seq_done) begin
        timeout_flag <= 1'b1;
      end
    end
  end

endmodule

// File: doc/seq_scheduler.md
Name: seq_scheduler

Overview:
- Per-frame run controller for the DSP sequencer.
- On each audio frame strobe it releases the sequencer from reset and advances the frame index. It then waits for `done`, holds the sequencer in reset again and records status: run length, overruns, errors and timeouts.
- Sits between the audio frame timing logic, the sequencer's `rst`/`frame`/`done`/`error` pins, and a CPU status/control register bank.

Parameters:
- FRAME_W, 4, width of frame index driven to sequencer.
- CYC_W, 10, width of the run-cycle counter and timeout.
- TIMEOUT, 1000, max cycles allowed in RUN before forced stop (must be < 2^CYC_W).
- SETTLE, 2, cycles in START during which seq_done is ignored (done pipeline flush).

Ports:
- ck  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous active-low reset.
- enable  in  1  CPU enable; low blocks new runs.
- frame_strobe  in  1  one-cycle pulse, new audio frame available.
- clear  in  1  one-cycle pulse, clears sticky status.
- seq_done  in  1  sequencer halt indication.
- seq_error  in  1  sequencer illegal-opcode indication.
- seq_run  out  1  drives sequencer rst; 1 = run, 0 = held in reset.
- frame  out  FRAME_W  frame index for sequencer.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse at end of each run.
- cycles_last  out  CYC_W  RUN-state cycle count of last completed run.
- overrun_cnt  out  8  strobes dropped while busy, saturating.
- error_flag  out  1  sticky, seq_error seen during a run.
- timeout_flag  out  1  sticky, a run hit TIMEOUT.

Behaviour:
- Reset: async assert (rst=0) forces state IDLE. All outputs go to 0: seq_run, frame, busy, frame_done, cycles_last, overrun_cnt, error_flag, timeout_flag. Internal counters go to 0. Release is synchronous to next posedge.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, START, RUN, FINISH.
- IDLE:
  - seq_run=0, busy=0.
  - If frame_strobe=1 and enable=1: frame <= frame+1 (wraps 2^FRAME_W-1 -> 0), settle counter <= 0, go START.
  - If frame_strobe=1 and enable=0: strobe ignored, no overrun count.
- START:
  - seq_run=1, busy=1; seq_done ignored.
  - After SETTLE cycles in START, go RUN with run counter = 0.
- RUN:
  - seq_run=1; run counter increments each cycle.
  - seq_done=1 -> go FINISH.
  - seq_error=1 in any RUN cycle sets error_flag.
  - Run counter reaching TIMEOUT-1 without seq_done -> set timeout_flag, go FINISH.
  - seq_done and timeout in the same cycle -> treated as done; timeout_flag not set.
- FINISH (exactly 1 cycle):
  - seq_run=0.
  - cycles_last <= run counter value on exit from RUN: cycles spent in RUN, including the done cycle.
  - frame_done=1 for this cycle; go IDLE. frame_done is low in every other state.
- Overrun: frame_strobe while state != IDLE -> overrun_cnt+1, saturating at 255. The strobe is dropped: frame not advanced, no queued run.
- enable falling mid-run: current run completes normally; only new starts are blocked.
- clear:
  - Zeroes overrun_cnt, error_flag and timeout_flag. Does not affect frame, cycles_last or state.
  - Clear and a set/increment in the same cycle -> clear wins.
- Latency: frame_strobe at cycle N -> frame and seq_run updated at N+1. A done-terminated run lasts SETTLE + (RUN cycles) + 1 cycles from START entry to IDLE.

Optional Feature:
- Macro SEQ_SCHED_WATCHDOG_EN.
- Defined: TIMEOUT watchdog active as described.
- Undefined: no timeout; RUN waits indefinitely for seq_done. timeout_flag is tied 0 and TIMEOUT is unused. The run counter still counts and saturates at 2^CYC_W-1 instead of wrapping.

Test Plan:
- Reset then enable=1, strobe; seq_done asserted 20 cycles after RUN entry -> frame=1, seq_run high 2+21 cycles, frame_done pulse, cycles_last=21, busy low after.
- 17 consecutive completed runs -> frame sequence 1..15,0,1; wrap with no glitch.
- 3 strobes during one run -> overrun_cnt=3, frame advanced only once; clear pulse -> overrun_cnt=0. Clear concurrent with a strobe-while-busy -> 0.
- seq_error pulse in RUN, then seq_done -> error_flag=1 sticky across the next clean run.
- seq_done never asserted (watchdog build) -> seq_run drops after TIMEOUT cycles in RUN, timeout_flag=1, cycles_last=1000. Non-watchdog build -> seq_run stays high 2000 cycles, timeout_flag=0.
- rst pulsed low mid-RUN (asynchronous, between edges) -> seq_run, frame, flags 0 immediately; next strobe restarts at frame=1.
